mult_div_unit: RTL
==================

// Module: mult_div_unit
// PURPOSE
//  Iterative HI/LO multiply/divide unit for the MIPS32 datapath. Sits directly downstream of
//  the register file: consumes its two read ports (rs -> ReadData1, rt -> ReadData2) and
//  executes MULT/MULTU/DIV/DIVU over multiple cycles, holding results in HI/LO.
//  Control stalls on busy; MFHI/MFLO read hi/lo; MTHI/MTLO write them back.
// PARAMETERS
//  WIDTH   32   operand width; hi/lo are WIDTH each; iteration count = WIDTH
// PORTS
//  clk       in   1      rising-edge clock, single clock domain
//  reset     in   1      synchronous, active-high
//  start     in   1      launch op; sampled only when busy=0
//  op        in   2      funct[1:0]: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  rs_data   in   WIDTH  multiplicand / dividend (register file ReadData1)
//  rt_data   in   WIDTH  multiplier / divisor (register file ReadData2)
//  mthi      in   1      write hi <= rs_data (MTHI)
//  mtlo      in   1      write lo <= rs_data (MTLO)
//  busy      out  1      op in flight; control stalls MFHI/MFLO and new mult/div ops
//  done      out  1      one-cycle pulse: hi/lo updated with new result
//  hi        out  WIDTH  HI register (product[63:32] / remainder)
//  lo        out  WIDTH  LO register (product[31:0] / quotient)
// BEHAVIOUR
//  - Reset (any cycle, including mid-op): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
//  - FSM: IDLE -start-> CALC (WIDTH cycles, counter WIDTH-1..0) -> FIX (1 cycle) -> IDLE.
//  - Start edge E (IDLE, start=1): latch op, |rs|,|rt| (abs only for signed ops), result
//    signs; busy=1 from E+1. CALC at edges E+1..E+WIDTH; FIX at edge E+WIDTH+1 writes hi/lo,
//    done=1 and busy=0 during the cycle following that edge (WIDTH+1 edges after start).
//  - Operands captured at start edge; later rs_data/rt_data changes have no effect.
//  - Multiply: shift-add, one multiplier bit/cycle into a 2*WIDTH accumulator. Signed: negate
//    64-bit product in FIX iff sign(rs)^sign(rt).
//  - Divide: restoring, one quotient bit/cycle. Signed: quotient negated iff signs differ;
//    remainder takes sign of dividend. 0x80000000 / -1 (DIV) -> lo=0x80000000, hi=0.
//  - Divide by zero (rt=0, DIV or DIVU): full latency kept; lo=32'hFFFF_FFFF, hi=rs_data
//    as captured (raw, unsigned) -- no trap.
//  - start while busy=1: ignored, no effect on in-flight op.
//  - mthi/mtlo: applied next edge only when busy=0 and start=0; both may be set together.
//    Ignored if busy=1. start and mthi/mtlo in same cycle: start wins, moves dropped.
//  - hi/lo hold value between writes; intermediate CALC values never visible on hi/lo.
//  - done never asserted outside the FIX->IDLE cycle; busy and done never high together.
// STRUCTURE
//  - Shared package mips_pkg: op encodings (OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10,
//    OP_DIVU=2'b11), funct constants 6'h18..6'h1B, 6'h10..6'h13, FSM state localparams.
//  - One sub-module natural: md_datapath (accumulator/remainder shift registers, add/sub,
//    counter); top holds FSM, sign fixup, hi/lo registers, mthi/mtlo.
// TESTING
//  1 MULT rs=7 rt=-3 -> done at start+33 edges, hi=FFFFFFFF lo=FFFFFFEB; busy high 32+1 cyc.
//  2 MULTU rs=rt=FFFFFFFF -> hi=FFFFFFFE lo=00000001; MULT same operands -> hi=0 lo=1.
//  3 DIVU 100/7 -> lo=0000000E hi=00000002; DIV -7/2 -> lo=FFFFFFFD hi=FFFFFFFF.
//  4 DIV 5/0 -> lo=FFFFFFFF hi=00000005 at normal latency; DIV 80000000/FFFFFFFF -> lo=80000000 hi=0.
//  5 start MULT, pulse start(DIVU) and mthi at cycle 10 -> both ignored, MULT result lands.
//  6 reset at cycle 15 of DIV -> next cycle busy=0 done=0 hi=lo=0; then mtlo rs=1234 -> lo=1234.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS32 HI/LO op encodings, funct codes and multiply/divide FSM states
package mips_pkg;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} md_state_e;
endpackage

// File: rtl/md_datapath.sv
// md_datapath: shift-add multiply / restoring divide core, one bit per cycle on magnitudes
module md_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             calc_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] b_init_i,
    input  logic [WIDTH-1:0] m_init_i,
    output logic [WIDTH-1:0] acc_hi_o,
    output logic [WIDTH-1:0] acc_lo_o,
    output logic             last_o
);
    localparam int CW = $clog2(WIDTH);
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, m_q, diff;
    logic [WIDTH:0]   sum, t;
    logic [CW-1:0]    cnt_q;
    logic             ge;
    // a holds upper product / partial remainder, b holds multiplier / dividend shifting into quotient
    always_comb begin
        sum  = {1'b0, a_q} + {1'b0, b_q[0] ? m_q : '0};
        t    = {a_q, b_q[WIDTH-1]};
        ge   = t >= {1'b0, m_q};
        diff = t[WIDTH-1:0] - m_q;
        a_d  = is_div_i ? (ge ? diff : t[WIDTH-1:0]) : sum[WIDTH:1];
        b_d  = is_div_i ? {b_q[WIDTH-2:0], ge} : {sum[0], b_q[WIDTH-1:1]};
    end
    // load operands on start, then iterate once per CALC cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            m_q   <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            a_q   <= '0;
            b_q   <= b_init_i;
            m_q   <= m_init_i;
            cnt_q <= CW'(WIDTH - 1);
        end else if (calc_i) begin
            a_q   <= a_d;
            b_q   <= b_d;
            cnt_q <= cnt_q - 1'b1;
        end
    end
    assign acc_hi_o = a_q;
    assign acc_lo_o = b_q;
    assign last_o   = cnt_q == '0;
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative HI/LO multiply/divide unit with MTHI/MTLO write-back
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    import mips_pkg::*;
    md_state_e          state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, rs_q, rs_abs, rt_abs, dp_hi, dp_lo;
    logic [2*WIDTH-1:0] prod_s;
    logic               done_q, done_d, is_div_q, neg_q, rneg_q, divz_q;
    logic               launch, rs_neg, rt_neg, last;
    assign launch = state_q == S_IDLE && start;
    assign rs_neg = ~op[0] & rs_data[WIDTH-1];
    assign rt_neg = ~op[0] & rt_data[WIDTH-1];
    assign rs_abs = rs_neg ? -rs_data : rs_data;
    assign rt_abs = rt_neg ? -rt_data : rt_data;
    md_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk      (clk),
        .reset    (reset),
        .load_i   (launch),
        .calc_i   (state_q == S_CALC),
        .is_div_i (is_div_q),
        .b_init_i (op[1] ? rs_abs : rt_abs),
        .m_init_i (op[1] ? rt_abs : rs_abs),
        .acc_hi_o (dp_hi),
        .acc_lo_o (dp_lo),
        .last_o   (last)
    );
    // next state, sign fixup of the magnitude result, and HI/LO moves while idle
    always_comb begin
        state_d = state_q == S_IDLE ? (start ? S_CALC : S_IDLE) :
                  state_q == S_CALC ? (last ? S_FIX : S_CALC) : S_IDLE;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        prod_s  = neg_q ? -{dp_hi, dp_lo} : {dp_hi, dp_lo};
        if (state_q == S_IDLE && !start) begin
            hi_d = mthi ? rs_data : hi_q;
            lo_d = mtlo ? rs_data : lo_q;
        end
        if (state_q == S_FIX) begin
            done_d = 1'b1;
            hi_d   = !is_div_q ? prod_s[2*WIDTH-1:WIDTH] : divz_q ? rs_q : rneg_q ? -dp_hi : dp_hi;
            lo_d   = !is_div_q ? prod_s[WIDTH-1:0] : divz_q ? '1 : neg_q ? -dp_lo : dp_lo;
        end
    end
    // state, result registers and per-op attributes captured at launch
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            divz_q   <= 1'b0;
            rs_q     <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            if (launch) begin
                is_div_q <= op[1];
                neg_q    <= rs_neg ^ rt_neg;
                rneg_q   <= rs_neg;
                divz_q   <= rt_data == '0;
                rs_q     <= rs_data;
            end
        end
    end
    assign busy = state_q != S_IDLE;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule
